// File: rtl/store_checker_pkg.sv
// Shared definitions for the store-stream checker.
// Holds the verdict encodings, the default pass/scratch constants used by the
// checker and its bench, and the packed layout of one trace entry.
package store_checker_pkg;

  localparam logic [1:0] VERDICT_RUN  = 2'b00;
  localparam logic [1:0] VERDICT_PASS = 2'b01;
  localparam logic [1:0] VERDICT_FAIL = 2'b10;

  localparam logic [31:0] DEF_PASS_ADDR    = 32'd84;
  localparam logic [31:0] DEF_PASS_DATA    = 32'd7;
  localparam logic [31:0] DEF_SCRATCH_ADDR = 32'd80;

  // One recorded store; address sits in the upper half of the 64-bit FIFO word.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } trace_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy count and sticky overflow.
// Ports:
//   i_clk, i_rst      clock, asynchronous active-low reset
//   i_push, i_wdata   write strobe and data
//   i_pop             pop request; ignored while empty
//   o_rdata           head entry (0 while empty)
//   o_full, o_empty   status flags derived from the count
//   o_count           occupancy, 0..DEPTH
//   o_overflow        sticky; a push was dropped because the FIFO was full
module sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count,
  output logic             o_overflow
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_pop   = i_pop & ~w_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push  = i_push & (~w_full | w_pop);
  assign w_drop  = i_push & w_full & ~w_pop;

  // Storage needs no reset: the head is masked while empty.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CNT_W'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign o_rdata    = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_full     = w_full;
  assign o_empty    = w_empty;
  assign o_count    = r_count;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/store_checker.sv
// Store-stream checker for the single-cycle MIPS data-memory port.
// Records every store into a trace FIFO and keeps a sticky pass/fail verdict.
// Ports:
//   i_clk, i_rst                         clock, asynchronous active-low reset
//   i_memwrite, i_dataadr, i_writedata   store strobe, address, data
//   o_rd_valid, i_rd_ready               trace read handshake
//   o_rd_addr, o_rd_data                 trace head (0 while empty)
//   o_count, o_overflow                  trace occupancy, sticky drop flag
//   o_store_cnt                          saturating count of all stores
//   o_verdict, o_done, o_fail_addr       verdict, decided flag, failing address
module store_checker
  import store_checker_pkg::*;
#(
  parameter int unsigned DEPTH        = 8,
  parameter logic [31:0] PASS_ADDR    = DEF_PASS_ADDR,
  parameter logic [31:0] PASS_DATA    = DEF_PASS_DATA,
  parameter logic [31:0] SCRATCH_ADDR = DEF_SCRATCH_ADDR,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_memwrite,
  input  logic [31:0]      i_dataadr,
  input  logic [31:0]      i_writedata,
  output logic             o_rd_valid,
  input  logic             i_rd_ready,
  output logic [31:0]      o_rd_addr,
  output logic [31:0]      o_rd_data,
  output logic [CNT_W-1:0] o_count,
  output logic             o_overflow,
  output logic [15:0]      o_store_cnt,
  output logic [1:0]       o_verdict,
  output logic             o_done,
  output logic [31:0]      o_fail_addr
);

  logic [1:0]   r_verdict;
  logic [1:0]   w_verdict_d;
  logic [31:0]  r_fail_addr;
  logic [31:0]  w_fail_addr_d;
  logic [15:0]  r_store_cnt;
  trace_entry_t w_wentry;
  trace_entry_t w_rentry;
  logic         w_empty;

  // Verdict is only decided from RUN; PASS and FAIL hold until reset.
  always_comb begin
    w_verdict_d   = r_verdict;
    w_fail_addr_d = r_fail_addr;
    if (i_memwrite && (r_verdict == VERDICT_RUN)) begin
      if (i_dataadr == PASS_ADDR) begin
        if (i_writedata == PASS_DATA) begin
          w_verdict_d = VERDICT_PASS;
        end else begin
          w_verdict_d   = VERDICT_FAIL;
          w_fail_addr_d = i_dataadr;
        end
      end else if (i_dataadr != SCRATCH_ADDR) begin
        w_verdict_d   = VERDICT_FAIL;
        w_fail_addr_d = i_dataadr;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_verdict   <= VERDICT_RUN;
      r_fail_addr <= '0;
      r_store_cnt <= '0;
    end else begin
      r_verdict   <= w_verdict_d;
      r_fail_addr <= w_fail_addr_d;
      if (i_memwrite && (r_store_cnt != 16'hFFFF)) begin
        r_store_cnt <= r_store_cnt + 16'd1;
      end
    end
  end

  assign w_wentry = '{addr: i_dataadr, data: i_writedata};

  sync_fifo #(
    .WIDTH($bits(trace_entry_t)),
    .DEPTH(DEPTH)
  ) u_trace_fifo (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_push    (i_memwrite),
    .i_wdata   (w_wentry),
    .i_pop     (i_rd_ready),
    .o_rdata   (w_rentry),
    .o_full    (),
    .o_empty   (w_empty),
    .o_count   (o_count),
    .o_overflow(o_overflow)
  );

  assign o_rd_valid  = ~w_empty;
  assign o_rd_addr   = w_rentry.addr;
  assign o_rd_data   = w_rentry.data;
  assign o_store_cnt = r_store_cnt;
  assign o_verdict   = r_verdict;
  assign o_done      = (r_verdict != VERDICT_RUN);
  assign o_fail_addr = r_fail_addr;

endmodule

// File: tb/tb_store_checker.sv
// Directed self-checking bench for store_checker.
module tb_store_checker;
  import store_checker_pkg::*;

  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        memwrite = 1'b0;
  logic [31:0] dataadr = '0;
  logic [31:0] writedata = '0;
  logic        rd_ready = 1'b0;
  logic        rd_valid;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;
  logic [3:0]  count;
  logic        overflow;
  logic [15:0] store_cnt;
  logic [1:0]  verdict;
  logic        done;
  logic [31:0] fail_addr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  store_checker #(
    .DEPTH       (DEPTH),
    .PASS_ADDR   (DEF_PASS_ADDR),
    .PASS_DATA   (DEF_PASS_DATA),
    .SCRATCH_ADDR(DEF_SCRATCH_ADDR)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_memwrite (memwrite),
    .i_dataadr  (dataadr),
    .i_writedata(writedata),
    .o_rd_valid (rd_valid),
    .i_rd_ready (rd_ready),
    .o_rd_addr  (rd_addr),
    .o_rd_data  (rd_data),
    .o_count    (count),
    .o_overflow (overflow),
    .o_store_cnt(store_cnt),
    .o_verdict  (verdict),
    .o_done     (done),
    .o_fail_addr(fail_addr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    memwrite  = 1'b1;
    dataadr   = a;
    writedata = d;
    @(negedge clk);
    memwrite  = 1'b0;
  endtask

  task automatic pop_one();
    @(negedge clk);
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_verdict"}, 32'(verdict), 32'(VERDICT_RUN));
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_fail_addr"}, fail_addr, 32'd0);
    check({tag, "_overflow"}, 32'(overflow), 32'd0);
    check({tag, "_store_cnt"}, 32'(store_cnt), 32'd0);
    check({tag, "_count"}, 32'(count), 32'd0);
    check({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    check({tag, "_rd_addr"}, rd_addr, 32'd0);
    check({tag, "_rd_data"}, rd_data, 32'd0);
  endtask

  // Safety net; every step below runs a fixed number of cycles.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    check_reset_values("reset");
    @(negedge clk);
    rst = 1'b1;

    // Scratch store then passing store
    store(32'd80, 32'd5);
    check("scratch_verdict", 32'(verdict), 32'(VERDICT_RUN));
    store(32'd84, 32'd7);
    check("pass_verdict", 32'(verdict), 32'(VERDICT_PASS));
    check("pass_done", 32'(done), 32'd1);
    check("pass_count", 32'(count), 32'd2);
    check("pass_store_cnt", 32'(store_cnt), 32'd2);
    check("pass_rd_valid", 32'(rd_valid), 32'd1);
    check("pass_head0_addr", rd_addr, 32'd80);
    check("pass_head0_data", rd_data, 32'd5);
    pop_one();
    check("pass_head1_addr", rd_addr, 32'd84);
    check("pass_head1_data", rd_data, 32'd7);
    check("pass_count_after_pop", 32'(count), 32'd1);
    pop_one();
    check("pass_rd_valid_empty", 32'(rd_valid), 32'd0);
    check("pass_count_empty", 32'(count), 32'd0);
    pop_one();  // rd_ready on empty FIFO is ignored
    check("empty_pop_count", 32'(count), 32'd0);

    // Wrong data at the pass address
    do_reset();
    store(32'd84, 32'd6);
    check("baddata_verdict", 32'(verdict), 32'(VERDICT_FAIL));
    check("baddata_fail_addr", fail_addr, 32'd84);
    store(32'd84, 32'd7);
    check("baddata_sticky_verdict", 32'(verdict), 32'(VERDICT_FAIL));
    check("baddata_sticky_fail_addr", fail_addr, 32'd84);

    // Store to a foreign address
    do_reset();
    store(32'd88, 32'd7);
    check("badaddr_verdict", 32'(verdict), 32'(VERDICT_FAIL));
    check("badaddr_fail_addr", fail_addr, 32'd88);
    store(32'd84, 32'd7);
    check("badaddr_sticky_verdict", 32'(verdict), 32'(VERDICT_FAIL));
    check("badaddr_sticky_fail_addr", fail_addr, 32'd88);
    check("badaddr_count", 32'(count), 32'd2);

    // Overflow: DEPTH+2 back-to-back stores with no reads
    do_reset();
    for (int i = 0; i < DEPTH + 2; i++) begin
      @(negedge clk);
      memwrite  = 1'b1;
      dataadr   = 32'd80;
      writedata = 32'(i);
    end
    @(negedge clk);
    memwrite = 1'b0;
    check("ovf_count", 32'(count), 32'(DEPTH));
    check("ovf_overflow", 32'(overflow), 32'd1);
    check("ovf_store_cnt", 32'(store_cnt), 32'(DEPTH + 2));
    check("ovf_verdict", 32'(verdict), 32'(VERDICT_RUN));
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("ovf_drain_valid%0d", i), 32'(rd_valid), 32'd1);
      check($sformatf("ovf_drain_data%0d", i), rd_data, 32'(i));
      check($sformatf("ovf_drain_addr%0d", i), rd_addr, 32'd80);
      pop_one();
    end
    check("ovf_drained_valid", 32'(rd_valid), 32'd0);
    check("ovf_drained_overflow", 32'(overflow), 32'd1);

    // Full FIFO with simultaneous push and pop
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      store(32'd80, 32'(100 + i));
    end
    check("full_count", 32'(count), 32'(DEPTH));
    @(negedge clk);
    memwrite  = 1'b1;
    dataadr   = 32'd80;
    writedata = 32'd200;
    rd_ready  = 1'b1;
    @(negedge clk);
    memwrite  = 1'b0;
    rd_ready  = 1'b0;
    check("full_pp_count", 32'(count), 32'(DEPTH));
    check("full_pp_overflow", 32'(overflow), 32'd0);
    check("full_pp_store_cnt", 32'(store_cnt), 32'(DEPTH + 1));
    check("full_pp_head", rd_data, 32'd101);
    for (int i = 0; i < DEPTH - 1; i++) begin
      pop_one();
    end
    check("full_pp_last_data", rd_data, 32'd200);
    check("full_pp_last_count", 32'(count), 32'd1);

    // Asynchronous reset between clock edges
    do_reset();
    store(32'd80, 32'd1);
    store(32'd80, 32'd2);
    store(32'd88, 32'd3);
    check("async_pre_verdict", 32'(verdict), 32'(VERDICT_FAIL));
    check("async_pre_count", 32'(count), 32'd3);
    #2;
    rst = 1'b0;
    #1;
    check_reset_values("async");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("async_post_rd_valid", 32'(rd_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
